// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - handshake bundle between input controllers, arbiter and downstream FIFO
//
// Purpose: groups every non-clock/reset signal of one router output port.
// Signals:
//   reqInCntr  [4:0]               per-input-controller request for this output
//   gntInCntr  [4:0]               one-hot, single-cycle grant back to the controllers
//   PacketIn   [5*dataWidth-1:0]   packet words, port i at [i*dataWidth +: dataWidth]
//   reqDnStr                       request to downstream FIFO, PacketOut valid while high
//   gntDnStr                       downstream grant
//   fullDnStr                      downstream FIFO full
//   PacketOut  [dataWidth-1:0]     word presented downstream
//   busy                           a captured word is pending
//   pktCount   [countWidth-1:0]    words accepted downstream since reset
// Modports: master = arbiter side, slave = surrounding router/environment side.
interface output_port_arbiter_if #(
  parameter int dataWidth  = 32,
  parameter int countWidth = 16
);
  logic [4:0]             reqInCntr;
  logic [4:0]             gntInCntr;
  logic [5*dataWidth-1:0] PacketIn;
  logic                   reqDnStr;
  logic                   gntDnStr;
  logic                   fullDnStr;
  logic [dataWidth-1:0]   PacketOut;
  logic                   busy;
  logic [countWidth-1:0]  pktCount;

  modport master (
    input  reqInCntr, PacketIn, gntDnStr, fullDnStr,
    output gntInCntr, reqDnStr, PacketOut, busy, pktCount
  );

  modport slave (
    output reqInCntr, PacketIn, gntDnStr, fullDnStr,
    input  gntInCntr, reqDnStr, PacketOut, busy, pktCount
  );
endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin output port arbiter with downstream req/gnt/full handshake
//
// Purpose: picks one of five input controllers (E0,N1,W2,S3,L4) round-robin,
// pulses its grant for one cycle, captures its word and offers it downstream
// until accepted. Counts accepted words.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    output_port_arbiter_if.master (see interface file for signal list)
module output_port_arbiter #(
  parameter int dataWidth  = 32,
  parameter int countWidth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output_port_arbiter_if.master  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state;
  logic [2:0]            r_last;
  logic [4:0]            r_gnt;
  logic [dataWidth-1:0]  r_pkt;
  logic [countWidth-1:0] r_cnt;

  state_t                w_state_nxt;
  logic [2:0]            w_last_nxt;
  logic [4:0]            w_gnt_nxt;
  logic [dataWidth-1:0]  w_pkt_nxt;
  logic [countWidth-1:0] w_cnt_nxt;

  logic [2:0]            w_idx;
  logic [2:0]            w_win;
  logic                  w_found;
  logic [dataWidth-1:0]  w_word;
  logic                  w_req_dn;

  // Round-robin search: start one past the last winner and wrap modulo 5.
  always_comb begin
    w_idx   = 3'd0;
    w_win   = 3'd0;
    w_found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w_idx = 3'((int'(r_last) + k) % 5);
      if (!w_found && bus.reqInCntr[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_word = '0;
    case (w_win)
      3'd0:    w_word = bus.PacketIn[0*dataWidth +: dataWidth];
      3'd1:    w_word = bus.PacketIn[1*dataWidth +: dataWidth];
      3'd2:    w_word = bus.PacketIn[2*dataWidth +: dataWidth];
      3'd3:    w_word = bus.PacketIn[3*dataWidth +: dataWidth];
      3'd4:    w_word = bus.PacketIn[4*dataWidth +: dataWidth];
      default: w_word = '0;
    endcase
  end

  // A full downstream FIFO masks the request, so a coincident gntDnStr cannot transfer.
  assign w_req_dn = (r_state == SEND) && !bus.fullDnStr;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = 5'b00000;
    w_pkt_nxt   = r_pkt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = SEND;
          w_last_nxt  = w_win;
          w_gnt_nxt   = 5'(5'b00001 << w_win);
          w_pkt_nxt   = w_word;
        end
      end
      SEND: begin
        if (w_req_dn && bus.gntDnStr) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = r_cnt + countWidth'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 3'd4;
      r_gnt   <= 5'b00000;
      r_pkt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_pkt   <= w_pkt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gntInCntr = r_gnt;
  assign bus.reqDnStr  = w_req_dn;
  assign bus.PacketOut = r_pkt;
  assign bus.busy      = (r_state == SEND);
  assign bus.pktCount  = r_cnt;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed and randomized self-checking bench for output_port_arbiter
module tb_output_port_arbiter;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.dataWidth(DW), .countWidth(CW)) bus();

  output_port_arbiter #(.dataWidth(DW), .countWidth(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Input controller stimulus
  logic [4:0]    req_v;
  logic [DW-1:0] word [5];
  logic          full_v;
  logic          gdn_v;

  // Reference model: busy flag, last granted port, captured word, accepted-word count
  bit            m_busy;
  int            m_last;
  logic [DW-1:0] m_word;
  int            m_count;
  logic [4:0]    m_gnt;

  int obs_grants[$];

  task automatic drive();
    bus.reqInCntr = req_v;
    for (int p = 0; p < 5; p++) bus.PacketIn[p*DW +: DW] = word[p];
    bus.fullDnStr = full_v;
    bus.gntDnStr  = gdn_v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("gntInCntr", 64'(bus.gntInCntr), 64'(m_gnt));
    chk("reqDnStr", 64'(bus.reqDnStr), 64'(m_busy && !full_v));
    chk("PacketOut", 64'(bus.PacketOut), 64'(m_word));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("pktCount", 64'(bus.pktCount), 64'(m_count));
    if (bus.gntInCntr != 5'b0) obs_grants.push_back($clog2(bus.gntInCntr));
  endtask

  task automatic model_step();
    int w;
    if (reset) begin
      m_busy = 0; m_last = 4; m_word = '0; m_count = 0; m_gnt = '0;
    end else if (!m_busy) begin
      m_gnt = '0;
      if (req_v != 5'b0) begin
        w = 0;
        for (int k = 1; k <= 5; k++) begin
          w = (m_last + k) % 5;
          if (req_v[w]) break;
        end
        m_busy = 1;
        m_gnt  = 5'(1 << w);
        m_word = word[w];
        m_last = w;
      end
    end else begin
      m_gnt = '0;
      if (!full_v && gdn_v) begin
        m_busy  = 0;
        m_count = (m_count + 1) % (1 << CW);
      end
    end
  endtask

  // Called at a falling edge after inputs are chosen; returns at the next falling edge.
  task automatic cyc();
    drive();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_v = '0; full_v = 1'b0; gdn_v = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_v = '0; full_v = 1'b0; gdn_v = 1'b0;
    for (int p = 0; p < 5; p++) word[p] = 32'hA5A5_0000 | 32'(p);
    m_busy = 0; m_last = 4; m_word = '0; m_count = 0; m_gnt = '0;
    drive();
    @(negedge clk);

    // 1: single request from port 2
    do_reset();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_cnt", 64'(bus.pktCount), 64'd0);
    req_v = 5'b00100; word[2] = 32'hA5A5_0002; gdn_v = 1'b1;
    cyc();
    req_v = 5'b00000;
    drive(); #1;
    chk("t1_gnt", 64'(bus.gntInCntr), 64'h04);
    chk("t1_reqdn", 64'(bus.reqDnStr), 64'd1);
    chk("t1_pkt", 64'(bus.PacketOut), 64'hA5A5_0002);
    cyc();
    chk("t1_cnt", 64'(bus.pktCount), 64'd1);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_gnt_off", 64'(bus.gntInCntr), 64'd0);

    // 2: all five request continuously
    do_reset();
    for (int p = 0; p < 5; p++) word[p] = 32'h5000_0000 | 32'(p);
    req_v = 5'b11111; gdn_v = 1'b1;
    obs_grants.delete();
    for (int i = 0; i < 12; i++) cyc();
    chk("t2_ngrants", 64'(obs_grants.size()), 64'd6);
    if (obs_grants.size() == 6) begin
      chk("t2_g0", 64'(obs_grants[0]), 64'd0);
      chk("t2_g1", 64'(obs_grants[1]), 64'd1);
      chk("t2_g2", 64'(obs_grants[2]), 64'd2);
      chk("t2_g3", 64'(obs_grants[3]), 64'd3);
      chk("t2_g4", 64'(obs_grants[4]), 64'd4);
      chk("t2_g5", 64'(obs_grants[5]), 64'd0);
    end
    chk("t2_cnt", 64'(bus.pktCount), 64'd6);

    // 3: downstream full stall
    do_reset();
    word[0] = 32'hC0DE_0000;
    req_v = 5'b00001; gdn_v = 1'b1;
    cyc();
    req_v = 5'b00000; full_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_reqdn", 64'(bus.reqDnStr), 64'd0);
      chk("t3_pkt", 64'(bus.PacketOut), 64'hC0DE_0000);
      chk("t3_cnt_hold", 64'(bus.pktCount), 64'd0);
    end
    full_v = 1'b0;
    cyc();
    chk("t3_cnt", 64'(bus.pktCount), 64'd1);
    chk("t3_busy", 64'(bus.busy), 64'd0);
    cyc(); cyc();
    chk("t3_cnt_once", 64'(bus.pktCount), 64'd1);

    // 4: ports 1 and 3 after port 3 was last granted
    do_reset();
    req_v = 5'b01000; gdn_v = 1'b1;
    cyc();
    req_v = 5'b00000;
    cyc();
    obs_grants.delete();
    req_v = 5'b01010;
    cyc();
    req_v = 5'b01000;
    cyc();
    cyc();
    req_v = 5'b00000;
    cyc();
    chk("t4_ngrants", 64'(obs_grants.size()), 64'd2);
    if (obs_grants.size() == 2) begin
      chk("t4_first", 64'(obs_grants[0]), 64'd1);
      chk("t4_second", 64'(obs_grants[1]), 64'd3);
    end

    // 5: reset while in SEND
    gdn_v = 1'b0;
    req_v = 5'b00100;
    cyc();
    req_v = 5'b00000;
    cyc();
    chk("t5_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(); #1;
    chk("t5_reqdn", 64'(bus.reqDnStr), 64'd0);
    chk("t5_gnt", 64'(bus.gntInCntr), 64'd0);
    chk("t5_cnt", 64'(bus.pktCount), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    req_v = 5'b10011; gdn_v = 1'b1;
    cyc();
    req_v = 5'b10010;
    drive(); #1;
    chk("t5_prio0", 64'(bus.gntInCntr), 64'h01);
    cyc();
    req_v = 5'b00000;
    cyc(); cyc();

    // 6: counter wrap
    do_reset();
    req_v = 5'b11111; gdn_v = 1'b1;
    for (int i = 0; i < 2 * ((1 << CW) - 1); i++) cyc();
    chk("t6_all_ones", 64'(bus.pktCount), 64'((1 << CW) - 1));
    cyc(); cyc();
    chk("t6_wrap", 64'(bus.pktCount), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 5; p++) begin
        if (m_gnt[p]) begin
          req_v[p] = 1'($urandom_range(0, 1));
          word[p]  = $urandom;
        end else if (!req_v[p] && ($urandom_range(0, 3) == 0)) begin
          req_v[p] = 1'b1;
          word[p]  = $urandom;
        end
      end
      full_v = ($urandom_range(0, 2) == 0);
      gdn_v  = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
